fl1p3_chain_seq: RTL and testbench

//  Sequencer for a chain of LEN mux-flops with clock enable (D0 functional input, D1 = Q of the

---
 rtl/fl1p3_chain_seq.sv | 155 +++++++++++++++
 tb/tb_fl1p3_chain_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fl1p3_chain_seq.sv
// ============================================================================
// Module  : fl1p3_chain_seq
// Purpose : Sequencer for the shared SP/SD lines of a LEN-deep mux-flop chain.
//           Runs an optional parallel capture followed by exactly LEN shifts.
//           Define FL1P3_CHAIN_SEQ_PARITY_EN to add the PAR output (parity of
//           the bits shifted out of the chain tail).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fl1p3_chain_seq #(
  parameter int LEN   = 8,
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             gsrn,
  input  logic             start,
  input  logic             mode,
  input  logic             hold,
  input  logic             abort,
  input  logic             so,
  output logic             sp,
  output logic             sd,
  output logic             busy,
  output logic             done,
`ifdef FL1P3_CHAIN_SEQ_PARITY_EN
  output logic [CNT_W-1:0] bitcnt,
  output logic             par
`else
  output logic [CNT_W-1:0] bitcnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_SHIFT   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LEN - 1);

  state_t r_state;

  // A shift happens on every edge where the chain is enabled in SHIFT (SD is 1 there).
  logic w_shift_edge;
  logic w_last_shift;
  logic w_accept;

  assign w_shift_edge = (r_state == S_SHIFT) && sp;
  assign w_last_shift = w_shift_edge && (bitcnt == C_LAST);
  assign w_accept     = (r_state == S_IDLE) && start && !abort;

  always_ff @(posedge ck or negedge gsrn) begin
    if (!gsrn) begin
      r_state <= S_IDLE;
      sp      <= 1'b0;
      sd      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bitcnt  <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          sp   <= 1'b0;
          sd   <= 1'b0;
          busy <= 1'b0;
          if (w_accept) begin
            bitcnt <= '0;
            busy   <= 1'b1;
            if (mode) begin
              r_state <= S_CAPTURE;
              sp      <= 1'b1;
              sd      <= 1'b0;
            end else begin
              r_state <= S_SHIFT;
              sp      <= ~hold;
              sd      <= 1'b1;
            end
          end
        end

        S_CAPTURE: begin
          if (abort) begin
            r_state <= S_IDLE;
            sp      <= 1'b0;
            sd      <= 1'b0;
            busy    <= 1'b0;
          end else begin
            r_state <= S_SHIFT;
            sp      <= ~hold;
            sd      <= 1'b1;
          end
        end

        S_SHIFT: begin
          // Abort freezes the count even when this edge would have shifted.
          if (abort) begin
            r_state <= S_IDLE;
            sp      <= 1'b0;
            sd      <= 1'b0;
            busy    <= 1'b0;
          end else begin
            if (w_shift_edge) begin
              bitcnt <= bitcnt + 1'b1;
            end
            if (w_last_shift) begin
              r_state <= S_DONE;
              sp      <= 1'b0;
              sd      <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              sp <= ~hold;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          sp      <= 1'b0;
          sd      <= 1'b0;
          busy    <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          sp      <= 1'b0;
          sd      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef FL1P3_CHAIN_SEQ_PARITY_EN
  always_ff @(posedge ck or negedge gsrn) begin
    if (!gsrn) begin
      par <= 1'b0;
    end else if (w_accept) begin
      par <= 1'b0;
    end else if (w_shift_edge) begin
      par <= par ^ so;
    end
  end
`else
  // Tail data only matters to the parity option.
  logic w_unused_so;
  assign w_unused_so = so;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fl1p3_chain_seq.sv
// ============================================================================
// Module  : tb_fl1p3_chain_seq
// Purpose : Self-checking bench for fl1p3_chain_seq with LEN=8.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fl1p3_chain_seq;

  localparam int LEN   = 8;
  localparam int CNT_W = 8;

  // {sp, sd, busy, done}
  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_CAP  = 4'b1010;
  localparam logic [3:0] F_SH1  = 4'b1110;
  localparam logic [3:0] F_SH0  = 4'b0110;
  localparam logic [3:0] F_DONE = 4'b0001;

  logic             ck;
  logic             gsrn;
  logic             start;
  logic             mode;
  logic             hold;
  logic             abort;
  logic             so;
  logic             sp;
  logic             sd;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bitcnt;
`ifdef FL1P3_CHAIN_SEQ_PARITY_EN
  logic             par;
`endif

  fl1p3_chain_seq #(.LEN(LEN), .CNT_W(CNT_W)) dut (
    .ck     (ck),
    .gsrn   (gsrn),
    .start  (start),
    .mode   (mode),
    .hold   (hold),
    .abort  (abort),
    .so     (so),
    .sp     (sp),
    .sd     (sd),
    .busy   (busy),
    .done   (done),
`ifdef FL1P3_CHAIN_SEQ_PARITY_EN
    .bitcnt (bitcnt),
    .par    (par)
`else
    .bitcnt (bitcnt)
`endif
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic             start;
    logic             mode;
    logic             hold;
    logic             abort;
    logic             so;
    logic [3:0]       flags;
    logic [CNT_W-1:0] cnt;
    logic             chk_par;
    logic             e_par;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic st, input logic md, input logic hd, input logic ab,
                              input logic so_i, input logic [3:0] fl, input int cnt,
                              input logic cp, input logic ep);
    vec_t r;
    r.start = st; r.mode = md; r.hold = hd; r.abort = ab; r.so = so_i;
    r.flags = fl; r.cnt = CNT_W'(cnt); r.chk_par = cp; r.e_par = ep;
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] fl, input logic [CNT_W-1:0] cnt);
    logic [CNT_W+3:0] act;
    logic [CNT_W+3:0] req;
    act = {sp, sd, busy, done, bitcnt};
    req = {fl, cnt};
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got sp/sd/busy/done=%b bitcnt=%0d, want %b bitcnt=%0d",
               name, act[CNT_W+3:CNT_W], act[CNT_W-1:0], fl, cnt);
    end
  endtask

  // Drive each queued vector, push its expectation, compare after the edge.
  task automatic run_vecs(input string name);
    vec_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; mode = vecs[i].mode; hold = vecs[i].hold;
      abort = vecs[i].abort; so = vecs[i].so;
      sb_q.push_back(vecs[i]);
      @(posedge ck); #1;
      e = sb_q.pop_front();
      check($sformatf("%s[%0d]", name, i), e.flags, e.cnt);
`ifdef FL1P3_CHAIN_SEQ_PARITY_EN
      if (e.chk_par) begin
        n_cmp++;
        if (par !== e.e_par) begin
          n_bad++;
          $display("FAIL %s[%0d] par: got %b, want %b", name, i, par, e.e_par);
        end
      end
`endif
    end
    vecs.delete();
    start = 0; mode = 0; hold = 0; abort = 0; so = 0;
  endtask

  initial begin
    logic [7:0] pat_a;
    int         wait_cnt;
    pat_a = 8'b1000_1101; // bit k = SO for shift k: 1,0,1,1,0,0,0,1
    gsrn = 1'b0; start = 0; mode = 0; hold = 0; abort = 0; so = 0;
    #2;
    check("reset_async", F_IDLE, 0);
    #10 gsrn = 1'b1;
    @(posedge ck); #1;
    check("reset_idle", F_IDLE, 0);

    // Capture + 8 shifts, parity pattern A.
    vecs.push_back(mk(1, 1, 0, 0, 0, F_CAP, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_SH1, 0, 1, 0));
    begin
      logic p;
      p = 1'b0;
      for (int k = 0; k < 7; k++) begin
        p = p ^ pat_a[k];
        vecs.push_back(mk(0, 0, 0, 0, pat_a[k], F_SH1, k + 1, 1, p));
      end
    end
    vecs.push_back(mk(0, 0, 0, 0, pat_a[7], F_DONE, 8, 1, 1'b0));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_IDLE, 8, 1, 1'b0));
    run_vecs("capshift");

    // Shift only, HOLD stalls three cycles after the 2nd shift; parity pattern 1,0,...
    vecs.push_back(mk(1, 0, 0, 0, 0, F_SH1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, F_SH1, 1, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, F_SH0, 2, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, F_SH0, 2, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, F_SH0, 2, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_SH1, 2, 1, 1));
    for (int k = 3; k <= 7; k++) vecs.push_back(mk(0, 0, 0, 0, 0, F_SH1, k, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_DONE, 8, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_IDLE, 8, 1, 1));
    run_vecs("hold");

    // Abort at BITCNT=5, restart, then START+ABORT together in IDLE.
    vecs.push_back(mk(1, 0, 0, 0, 0, F_SH1, 0, 0, 0));
    for (int k = 1; k <= 5; k++) vecs.push_back(mk(0, 0, 0, 0, 0, F_SH1, k, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, F_IDLE, 5, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_IDLE, 5, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, F_SH1, 0, 0, 0));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(0, 0, 0, 0, 0, F_SH1, k, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_DONE, 8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_IDLE, 8, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, F_IDLE, 8, 0, 0));
    run_vecs("abort");

    // START held: back-to-back sequences, MODE toggling while busy has no effect.
    vecs.push_back(mk(1, 0, 0, 0, 0, F_SH1, 0, 0, 0));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(1, k[0], 0, 0, 0, F_SH1, k, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, F_DONE, 8, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, F_IDLE, 8, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, F_SH1, 0, 0, 0));
    for (int k = 1; k <= 7; k++) vecs.push_back(mk(0, 0, 0, 0, 0, F_SH1, k, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_DONE, 8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, F_IDLE, 8, 0, 0));
    run_vecs("b2b");

    // Asynchronous reset mid-shift at BITCNT=3.
    start = 1; mode = 0;
    @(posedge ck); #1;
    start = 0;
    wait_cnt = 0;
    while (bitcnt != 3 && wait_cnt < 20) begin
      @(posedge ck); #1;
      wait_cnt++;
    end
    n_cmp++;
    if (bitcnt != 3) begin
      n_bad++;
      $display("FAIL rst_mid wait: got bitcnt=%0d, want 3 within 20 cycles", bitcnt);
    end
    check("rst_mid_pre", F_SH1, 3);
    #2 gsrn = 1'b0;
    #1;
    check("rst_mid_async", F_IDLE, 0);
`ifdef FL1P3_CHAIN_SEQ_PARITY_EN
    n_cmp++;
    if (par !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid par: got %b, want 0", par);
    end
`endif
    @(negedge ck);
    gsrn = 1'b1;
    @(posedge ck); #1;
    check("rst_mid_idle", F_IDLE, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
